// File: rtl/priority_encoder.sv
// Registered priority encoder: reports the index of the winning request bit
// one clock after sampling, plus an idle flag when no request is present.
// MSB_FIRST selects whether the highest or the lowest set bit wins.
module priority_encoder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  output logic             idle,
  output logic [OUT_W-1:0] Out
);

  logic [OUT_W-1:0] out_next;
  logic             idle_next;

  // Scans in the direction that lets the winning bit be the last match.
  // With no bits set, the index stays at 0.
  function automatic logic [OUT_W-1:0] encode(input logic [WIDTH-1:0] req);
    logic [OUT_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) idx = OUT_W'(i);
      end
    end
    return idx;
  endfunction

  // Combinational encode of the current request vector.
  always_comb begin
    out_next  = encode(In);
    idle_next = (In == '0);
  end

  // Output register; reset forces index 0 and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Out  <= '0;
      idle <= 1'b1;
    end else begin
      Out  <= out_next;
      idle <= idle_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: one instance per priority
// direction, both fed the same request vector and checked against an
// arithmetic reference model.
module tb_priority_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] in_vec;
  logic       idle_msb, idle_lsb;
  logic [2:0] out_msb, out_lsb;

  int checks = 0;
  int errors = 0;

  priority_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .In(in_vec), .idle(idle_msb), .Out(out_msb)
  );

  priority_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .In(in_vec), .idle(idle_lsb), .Out(out_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(log2(v)) for v > 0, else 0
  function automatic int ref_msb(input int v);
    int n;
    n = 0;
    while (v > 1) begin
      v = v / 2;
      n++;
    end
    return n;
  endfunction

  // number of trailing zeros for v > 0, else 0
  function automatic int ref_lsb(input int v);
    int n;
    if (v == 0) return 0;
    n = 0;
    while ((v % 2) == 0) begin
      v = v / 2;
      n++;
    end
    return n;
  endfunction

  // Apply a value, let one rising edge capture it, settle just after.
  task automatic apply(input logic [7:0] v);
    in_vec = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    in_vec = 8'hFF;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_msb !== 3'd0 || idle_msb !== 1'b1 || out_lsb !== 3'd0 || idle_lsb !== 1'b1) begin
      errors++;
      $display("FAIL reset_immediate: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=0 idle=1",
               out_msb, idle_msb, out_lsb, idle_lsb);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_msb !== 3'd0 || idle_msb !== 1'b1 || out_lsb !== 3'd0 || idle_lsb !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=0 idle=1",
                 out_msb, idle_msb, out_lsb, idle_lsb);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    apply(8'hFF);
    checks++;
    if (out_msb !== 3'd7 || idle_msb !== 1'b0 || out_lsb !== 3'd0 || idle_lsb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want msb 7/0 lsb 0/0",
               out_msb, idle_msb, out_lsb, idle_lsb);
    end
  endtask

  task automatic test_zero_input;
    apply(8'h00);
    checks++;
    if (out_msb !== 3'd0 || idle_msb !== 1'b1 || out_lsb !== 3'd0 || idle_lsb !== 1'b1) begin
      errors++;
      $display("FAIL zero_input: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=0 idle=1",
               out_msb, idle_msb, out_lsb, idle_lsb);
    end
    apply(8'h01);
    checks++;
    if (out_msb !== 3'd0 || idle_msb !== 1'b0 || out_lsb !== 3'd0 || idle_lsb !== 1'b0) begin
      errors++;
      $display("FAIL bit0_input: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=0 idle=0",
               out_msb, idle_msb, out_lsb, idle_lsb);
    end
  endtask

  task automatic test_walking_one;
    for (int k = 0; k < 8; k++) begin
      apply(8'(1 << k));
      checks++;
      if (out_msb !== 3'(k) || out_lsb !== 3'(k) || idle_msb !== 1'b0 || idle_lsb !== 1'b0) begin
        errors++;
        $display("FAIL walking_one k=%0d: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=%0d idle=0",
                 k, out_msb, idle_msb, out_lsb, idle_lsb, k);
      end
    end
  endtask

  task automatic test_priority_mask;
    logic [7:0] vals [3];
    logic [2:0] want [3];
    vals[0] = 8'b0010_1101; want[0] = 3'b101;
    vals[1] = 8'b1000_0001; want[1] = 3'b111;
    vals[2] = 8'b0011_1111; want[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      apply(vals[i]);
      checks++;
      if (out_msb !== want[i] || idle_msb !== 1'b0) begin
        errors++;
        $display("FAIL priority_msb in=%b: Out=%0d idle=%0b, want Out=%0d idle=0",
                 vals[i], out_msb, idle_msb, want[i]);
      end
      checks++;
      if (out_lsb !== 3'(ref_lsb(int'(vals[i]))) || idle_lsb !== 1'b0) begin
        errors++;
        $display("FAIL priority_lsb in=%b: Out=%0d idle=%0b, want Out=%0d idle=0",
                 vals[i], out_lsb, idle_lsb, ref_lsb(int'(vals[i])));
      end
    end
  endtask

  task automatic test_random_stream;
    int v;
    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(63, 0));
      apply(8'(v));
      checks++;
      if (out_msb !== 3'(ref_msb(v)) || idle_msb !== (v == 0) || out_msb > 3'd5) begin
        errors++;
        $display("FAIL random_msb in=%0d: Out=%0d idle=%0b, want Out=%0d idle=%0b",
                 v, out_msb, idle_msb, ref_msb(v), (v == 0));
      end
      checks++;
      if (out_lsb !== 3'(ref_lsb(v)) || idle_lsb !== (v == 0)) begin
        errors++;
        $display("FAIL random_lsb in=%0d: Out=%0d idle=%0b, want Out=%0d idle=%0b",
                 v, out_lsb, idle_lsb, ref_lsb(v), (v == 0));
      end
    end
  endtask

  task automatic test_async_reset_midstream;
    apply(8'h40);
    checks++;
    if (out_msb !== 3'd6 || idle_msb !== 1'b0) begin
      errors++;
      $display("FAIL midstream_pre: Out=%0d idle=%0b, want Out=6 idle=0", out_msb, idle_msb);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_msb !== 3'd0 || idle_msb !== 1'b1 || out_lsb !== 3'd0 || idle_lsb !== 1'b1) begin
      errors++;
      $display("FAIL midstream_async: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=0 idle=1",
               out_msb, idle_msb, out_lsb, idle_lsb);
    end
    in_vec = 8'hFF;
    @(posedge clk);
    #1;
    checks++;
    if (out_msb !== 3'd0 || idle_msb !== 1'b1) begin
      errors++;
      $display("FAIL midstream_hold: Out=%0d idle=%0b, want Out=0 idle=1", out_msb, idle_msb);
    end
    @(negedge clk);
    in_vec = 8'h40;
    rst = 1'b0;
    apply(8'h40);
    checks++;
    if (out_msb !== 3'd6 || idle_msb !== 1'b0 || out_lsb !== 3'd6 || idle_lsb !== 1'b0) begin
      errors++;
      $display("FAIL midstream_release: msb Out=%0d idle=%0b lsb Out=%0d idle=%0b, want Out=6 idle=0",
               out_msb, idle_msb, out_lsb, idle_lsb);
    end
  endtask

  initial begin
    rst    = 1'b0;
    in_vec = 8'h00;
    test_reset();
    test_zero_input();
    test_walking_one();
    test_priority_mask();
    test_random_stream();
    test_async_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
